// File: rtl/tft_rd_if.sv
// Read port between the frame fetch engine (requester) and the SDRAM arbiter.
// Each request is a 4-word burst.
interface tft_rd_if;
    logic        oRd_Req;
    logic [23:0] oRd_Addr;
    logic        iRd_Done;
    logic [15:0] iRd_Data1;
    logic [15:0] iRd_Data2;
    logic [15:0] iRd_Data3;
    logic [15:0] iRd_Data4;

    modport master (
        output oRd_Req, oRd_Addr,
        input  iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4
    );

    modport slave (
        input  oRd_Req, oRd_Addr,
        output iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4
    );
endinterface

// File: rtl/tft_frame_fetch.sv
// Frame-buffer fetch engine: issues 4-word bursts from a linearly advancing address
// and feeds the returned words into a show-ahead pixel FIFO for the LCD timing generator.
module tft_frame_fetch #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          FRAME_WORDS = 130560,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          iFrame_Start,
    tft_rd_if.master                      rd,
    input  logic                          iPix_Rd,
    output logic [15:0]                   oPix_Data,
    output logic                          oPix_Valid,
    output logic [$clog2(FIFO_DEPTH):0]   oFill,
    output logic                          oUnderflow
);
    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [23:0] END_ADDR = BASE_ADDR + 24'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        req_q, req_d;
    logic [23:0] rd_addr_q, rd_addr_d;
    logic [23:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic        cap_en;
    logic [15:0] cap_q [4];

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q;
    logic             underflow_q;
    logic             push, pop;
    logic [PTR_W+1:0] space;
    logic [23:0]      addr_inc;

    always_comb begin
        pop       = iPix_Rd && (fill_q != '0);
        // Free space counts a pop happening this cycle.
        space     = (PTR_W+2)'(FIFO_DEPTH) - {1'b0, fill_q} + {{(PTR_W+1){1'b0}}, pop};
        addr_inc  = addr_q + 24'd4;
        state_d   = state_q;
        idx_d     = idx_q;
        req_d     = req_q;
        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        cap_en    = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !iFrame_Start && space >= (PTR_W+2)'(4)) begin
                    state_d   = REQ;
                    req_d     = 1'b1;
                    rd_addr_d = addr_q;
                end
            end
            REQ: begin
                // The arbiter cannot be aborted; a frame restart marks the burst for discard.
                if (iFrame_Start) discard_d = 1'b1;
                if (rd.iRd_Done) begin
                    req_d     = 1'b0;
                    discard_d = 1'b0;
                    if (discard_q || iFrame_Start) begin
                        state_d = IDLE;
                    end else begin
                        cap_en  = 1'b1;
                        state_d = PUSH;
                        idx_d   = 2'd0;
                        addr_d  = (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
                    end
                end
            end
            PUSH: begin
                if (iFrame_Start) begin
                    state_d = IDLE;
                end else begin
                    push  = 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (iFrame_Start) addr_d = BASE_ADDR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            req_q     <= 1'b0;
            rd_addr_q <= BASE_ADDR;
            addr_q    <= BASE_ADDR;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            req_q     <= req_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_q[0] <= rd.iRd_Data1;
            cap_q[1] <= rd.iRd_Data2;
            cap_q[2] <= rd.iRd_Data3;
            cap_q[3] <= rd.iRd_Data4;
        end
        if (push) mem_q[wr_ptr_q] <= cap_q[idx_q];
    end

    // Flush takes priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || iFrame_Start) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      fill_q <= fill_q + 1'b1;
            else if (!push && pop) fill_q <= fill_q - 1'b1;
            if (iPix_Rd && fill_q == '0) underflow_q <= 1'b1;
        end
    end

    always_comb begin
        rd.oRd_Req  = req_q;
        rd.oRd_Addr = rd_addr_q;
        oPix_Valid  = (fill_q != '0);
        oPix_Data   = oPix_Valid ? mem_q[rd_ptr_q] : 16'h0000;
        oFill       = fill_q;
        oUnderflow  = underflow_q;
    end
endmodule

// File: tb/tb_tft_frame_fetch.sv
// Directed bench for tft_frame_fetch: a full-size instance and a short-frame instance
// (FRAME_WORDS=8) served by a scripted arbiter inside one linear stimulus sequence.
module tb_tft_frame_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, fs = 1'b0, pix_rd = 1'b0;
    logic en_s = 1'b0, fs_s = 1'b0, pix_rd_s = 1'b0;
    logic [15:0] pix_data, pix_data_s;
    logic        pix_valid, pix_valid_s;
    logic [4:0]  fill, fill_s;
    logic        unf, unf_s;
    int checks = 0;
    int errors = 0;

    tft_rd_if rif ();
    tft_rd_if rif_s ();

    always #5 clk = ~clk;

    tft_frame_fetch #(.BASE_ADDR(24'h000000), .FRAME_WORDS(130560), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .iFrame_Start(fs), .rd(rif),
        .iPix_Rd(pix_rd), .oPix_Data(pix_data), .oPix_Valid(pix_valid),
        .oFill(fill), .oUnderflow(unf)
    );

    tft_frame_fetch #(.BASE_ADDR(24'h000000), .FRAME_WORDS(8), .FIFO_DEPTH(16)) u_small (
        .clk(clk), .rst(rst), .en(en_s), .iFrame_Start(fs_s), .rd(rif_s),
        .iPix_Rd(pix_rd_s), .oPix_Data(pix_data_s), .oPix_Valid(pix_valid_s),
        .oFill(fill_s), .oUnderflow(unf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scripted arbiter: wait (bounded) for the request, hold for lat cycles, pulse done.
    task automatic serve(input bit sel, input logic [23:0] a, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3, input logic [15:0] d4,
                         input int lat);
        int n;
        n = 0;
        while ((sel ? rif_s.oRd_Req : rif.oRd_Req) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_issue", sel ? rif_s.oRd_Req : rif.oRd_Req, 1);
        check("req_addr", sel ? rif_s.oRd_Addr : rif.oRd_Addr, a);
        repeat (lat) begin
            tick();
            check("req_hold", sel ? rif_s.oRd_Req : rif.oRd_Req, 1);
        end
        if (sel) begin
            rif_s.iRd_Data1 = d1; rif_s.iRd_Data2 = d2;
            rif_s.iRd_Data3 = d3; rif_s.iRd_Data4 = d4;
            rif_s.iRd_Done  = 1'b1;
        end else begin
            rif.iRd_Data1 = d1; rif.iRd_Data2 = d2;
            rif.iRd_Data3 = d3; rif.iRd_Data4 = d4;
            rif.iRd_Done  = 1'b1;
        end
        tick();
        rif.iRd_Done   = 1'b0;
        rif_s.iRd_Done = 1'b0;
        check("req_release", sel ? rif_s.oRd_Req : rif.oRd_Req, 0);
    endtask

    initial begin
        rif.iRd_Done = 1'b0;
        rif.iRd_Data1 = '0; rif.iRd_Data2 = '0; rif.iRd_Data3 = '0; rif.iRd_Data4 = '0;
        rif_s.iRd_Done = 1'b0;
        rif_s.iRd_Data1 = '0; rif_s.iRd_Data2 = '0; rif_s.iRd_Data3 = '0; rif_s.iRd_Data4 = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req", rif.oRd_Req, 0);
        check("rst_addr", rif.oRd_Addr, 24'h000000);
        check("rst_fill", fill, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 16'h0000);
        check("rst_unf", unf, 0);

        // Fill the FIFO with four bursts, no pops.
        en = 1'b1;
        serve(1'b0, 24'h000000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2);
        repeat (4) tick();
        check("b1_fill", fill, 4);
        check("b1_head", pix_data, 16'h1111);
        check("b1_valid", pix_valid, 1);
        serve(1'b0, 24'h000004, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1);
        serve(1'b0, 24'h000008, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 0);
        serve(1'b0, 24'h00000C, 16'hB001, 16'hB002, 16'hB003, 16'hB004, 3);
        repeat (6) tick();
        check("full_fill", fill, 16);
        check("full_noreq", rif.oRd_Req, 0);

        // Drain one word: no request.
        check("pop1_head", pix_data, 16'h1111);
        pix_rd = 1'b1;
        tick();
        pix_rd = 1'b0;
        check("pop1_next", pix_data, 16'h2222);
        check("pop1_fill", fill, 15);
        repeat (3) tick();
        check("pop1_noreq", rif.oRd_Req, 0);

        // Drain three more: the fourth pop frees enough space for one request.
        pix_rd = 1'b1;
        tick();
        check("pop2_next", pix_data, 16'h3333);
        check("pop2_noreq", rif.oRd_Req, 0);
        tick();
        check("pop3_next", pix_data, 16'h4444);
        check("pop3_noreq", rif.oRd_Req, 0);
        tick();
        pix_rd = 1'b0;
        check("pop4_next", pix_data, 16'h5555);
        check("pop4_fill", fill, 12);
        check("pop4_req", rif.oRd_Req, 1);
        check("pop4_addr", rif.oRd_Addr, 24'h000010);
        serve(1'b0, 24'h000010, 16'hC001, 16'hC002, 16'hC003, 16'hC004, 1);
        repeat (6) tick();
        check("refill_fill", fill, 16);
        check("refill_noreq", rif.oRd_Req, 0);

        // Flush, then pop on empty.
        en = 1'b0;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("flush_fill", fill, 0);
        check("flush_valid", pix_valid, 0);
        check("flush_data", pix_data, 16'h0000);
        pix_rd = 1'b1;
        tick();
        pix_rd = 1'b0;
        check("unf_set", unf, 1);
        check("unf_fill", fill, 0);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("unf_clear", unf, 0);

        // Frame start while a request to 0x000008 is outstanding.
        en = 1'b1;
        serve(1'b0, 24'h000000, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 0);
        serve(1'b0, 24'h000004, 16'hD005, 16'hD006, 16'hD007, 16'hD008, 0);
        for (int i = 0; i < 50 && rif.oRd_Req !== 1'b1; i++) tick();
        check("disc_req", rif.oRd_Req, 1);
        check("disc_addr", rif.oRd_Addr, 24'h000008);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("disc_hold", rif.oRd_Req, 1);
        check("disc_addr_hold", rif.oRd_Addr, 24'h000008);
        check("disc_fill0", fill, 0);
        tick();
        check("disc_hold2", rif.oRd_Req, 1);
        rif.iRd_Data1 = 16'hE001; rif.iRd_Data2 = 16'hE002;
        rif.iRd_Data3 = 16'hE003; rif.iRd_Data4 = 16'hE004;
        rif.iRd_Done = 1'b1;
        tick();
        rif.iRd_Done = 1'b0;
        check("disc_release", rif.oRd_Req, 0);
        check("disc_fill1", fill, 0);
        tick();
        check("disc_fill2", fill, 0);
        check("disc_next_req", rif.oRd_Req, 1);
        check("disc_next_addr", rif.oRd_Addr, 24'h000000);

        // Frame start on the second push together with a pop.
        rif.iRd_Data1 = 16'hF001; rif.iRd_Data2 = 16'hF002;
        rif.iRd_Data3 = 16'hF003; rif.iRd_Data4 = 16'hF004;
        rif.iRd_Done = 1'b1;
        tick();
        rif.iRd_Done = 1'b0;
        check("pab_release", rif.oRd_Req, 0);
        tick();
        check("pab_fill1", fill, 1);
        check("pab_head", pix_data, 16'hF001);
        fs = 1'b1;
        pix_rd = 1'b1;
        tick();
        fs = 1'b0;
        pix_rd = 1'b0;
        check("pab_fill0", fill, 0);
        check("pab_valid", pix_valid, 0);
        tick();
        check("pab_fill_after", fill, 0);
        check("pab_idle_req", rif.oRd_Req, 1);
        check("pab_idle_addr", rif.oRd_Addr, 24'h000000);
        en = 1'b0;

        // Short frame of 8 words: addresses wrap 0, 4, 0.
        en_s = 1'b1;
        serve(1'b1, 24'h000000, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 1);
        serve(1'b1, 24'h000004, 16'h0505, 16'h0606, 16'h0707, 16'h0808, 1);
        serve(1'b1, 24'h000000, 16'h0909, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1);
        en_s = 1'b0;
        repeat (4) tick();
        check("wrap_fill", fill_s, 12);
        check("wrap_head", pix_data_s, 16'h0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
